// File: rtl/bcd_count_sequencer.sv
// Preset timer/stopwatch controller: owns a cascaded BCD up/down counter,
// sequences load/start/stop/resume through a prescaler and flags terminal count.
module bcd_count_sequencer #(
  parameter int unsigned DIGITS   = 2,
  parameter int unsigned PRESCALE = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   preset,
  input  logic                  up_down,
  input  logic                  start,
  input  logic                  stop,
  output logic [4*DIGITS-1:0]   digits_out,
  output logic [1:0]            state_out,
  output logic                  running,
  output logic                  done,
  output logic                  err
);

  localparam int unsigned DW = 4 * DIGITS;
  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [DW-1:0]   digits_q, digits_d;
  logic [PW-1:0]   pre_q, pre_d;
  logic            dir_q, dir_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic            running_q, running_d;

  logic [DW-1:0]   stepped_c;
  logic [3:0]      nib_c;
  logic            carry_c;
  logic            preset_ok_c;

  // True when every digit sits at the end value for the given direction.
  function automatic logic is_term(input logic [DW-1:0] v, input logic up);
    logic t;
    t = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (v[4*i +: 4] != (up ? 4'd9 : 4'd0)) t = 1'b0;
    end
    return t;
  endfunction

  // One BCD step with ripple carry (up) or borrow (down).
  always_comb begin
    stepped_c = digits_q;
    carry_c   = 1'b1;
    nib_c     = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      nib_c = digits_q[4*i +: 4];
      if (carry_c) begin
        if (dir_q) begin
          if (nib_c == 4'd9) begin
            nib_c   = 4'd0;
            carry_c = 1'b1;
          end else begin
            nib_c   = nib_c + 4'd1;
            carry_c = 1'b0;
          end
        end else begin
          if (nib_c == 4'd0) begin
            nib_c   = 4'd9;
            carry_c = 1'b1;
          end else begin
            nib_c   = nib_c - 4'd1;
            carry_c = 1'b0;
          end
        end
      end
      stepped_c[4*i +: 4] = nib_c;
    end
  end

  always_comb begin
    preset_ok_c = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (preset[4*i +: 4] > 4'd9) preset_ok_c = 1'b0;
    end
  end

  // Next-state: clear > stop > start > load > tick.
  always_comb begin
    state_d  = state_q;
    digits_d = digits_q;
    pre_d    = pre_q;
    dir_d    = dir_q;
    err_d    = err_q;
    done_d   = 1'b0;

    if (clear) begin
      state_d  = IDLE;
      digits_d = '0;
      pre_d    = '0;
      err_d    = 1'b0;
    end else if (stop) begin
      if (state_q == RUN) state_d = HOLD;
    end else if (start && state_q != RUN) begin
      state_d = RUN;
      if (state_q != HOLD) begin
        pre_d = '0;
        dir_d = up_down;
      end
    end else if (load && state_q != RUN) begin
      if (preset_ok_c) begin
        digits_d = preset;
        err_d    = 1'b0;
        state_d  = IDLE;
      end else begin
        err_d = 1'b1;
      end
    end else if (state_q == RUN) begin
      if (is_term(digits_q, dir_q)) begin
        // Started already at terminal: finish without stepping.
        state_d = DONE;
        done_d  = 1'b1;
      end else if (pre_q == PRE_LAST) begin
        pre_d    = '0;
        digits_d = stepped_c;
        if (is_term(stepped_c, dir_q)) begin
          state_d = DONE;
          done_d  = 1'b1;
        end
      end else begin
        pre_d = pre_q + PW'(1);
      end
    end

    running_d = (state_d == RUN);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      digits_q  <= '0;
      pre_q     <= '0;
      dir_q     <= 1'b1;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      digits_q  <= digits_d;
      pre_q     <= pre_d;
      dir_q     <= dir_d;
      done_q    <= done_d;
      err_q     <= err_d;
      running_q <= running_d;
    end
  end

  assign digits_out = digits_q;
  assign state_out  = state_q;
  assign running    = running_q;
  assign done       = done_q;
  assign err        = err_q;

endmodule
